// File: rtl/digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_serial_adder: adds two WIDTH-bit operands one 3-bit digit per cycle.  |
// | Optional DIGIT_SERIAL_OVF_EN adds a signed-overflow flag output (ovf).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module digit_serial_adder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef DIGIT_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / 3;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            carry;
  logic [CW-1:0]   count;
  logic [2:0]      dig_a;
  logic [2:0]      dig_b;
  logic [3:0]      dig_sum;
  logic            accept;
  logic            last;

  always_comb begin
    dig_a = a_q[3*int'(count) +: 3];
    dig_b = b_q[3*int'(count) +: 3];
  end

  assign dig_sum = {1'b0, dig_a} + {1'b0, dig_b} + {3'b000, carry};
  assign accept  = (state == IDLE) && in_valid;
  assign last    = (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == RUN) begin
      sum[3*int'(count) +: 3] <= dig_sum[2:0];
      carry <= dig_sum[3];
      count <= count + CW'(1);
      if (last) cout <= dig_sum[3];
    end
  end

`ifdef DIGIT_SERIAL_OVF_EN
  // Carry into the MSB is recovered as sum ^ a ^ b at that bit position.
  always_ff @(posedge clk) begin
    if (rst || accept) ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= dig_sum[2] ^ dig_a[2] ^ dig_b[2] ^ dig_sum[3];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// Scoreboard bench for digit_serial_adder: a WIDTH=12 and a WIDTH=3 instance.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  typedef struct {
    logic [11:0] s;
    logic        c;
    logic        o;
  } exp_t;

  // ---------------- WIDTH=12 instance ----------------
  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic [11:0] a = '0, b = '0;
  wire         in_ready, out_valid, cout, busy;
  wire  [11:0] sum;
`ifdef DIGIT_SERIAL_OVF_EN
  wire         ovf;
`endif

  digit_serial_adder #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef DIGIT_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  // ---------------- WIDTH=3 instance ----------------
  logic       v3 = 1'b0, c3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  wire        rdy3, ov3, co3, busy3;
  wire  [2:0] s3;
`ifdef DIGIT_SERIAL_OVF_EN
  wire        ovf3;
`endif

  digit_serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
    .a(a3), .b(b3), .cin(c3), .out_valid(ov3), .out_ready(1'b1),
    .sum(s3), .cout(co3), .busy(busy3)
`ifdef DIGIT_SERIAL_OVF_EN
    , .ovf(ovf3)
`endif
  );

  exp_t q[$];
  exp_t q3[$];

  // Monitors: latency from accept to out_valid rise, and result on handshake.
  logic prev_ov = 1'b0, prev_ov3 = 1'b0;
  int   acc_cyc = 0, acc_cyc3 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid && !prev_ov) chk("latency12", cyc - acc_cyc, 4);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_result12", 32'(q.size()), 1);
        else begin
          e = q.pop_front();
          chk("sum12", 32'(sum), 32'(e.s));
          chk("cout12", 32'(cout), 32'(e.c));
`ifdef DIGIT_SERIAL_OVF_EN
          chk("ovf12", 32'(ovf), 32'(e.o));
`endif
        end
      end
    end
    prev_ov = out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v3 && rdy3) acc_cyc3 = cyc + 1;
      if (ov3 && !prev_ov3) chk("latency3", cyc - acc_cyc3, 1);
      if (ov3) begin
        if (q3.size() == 0) chk("unexpected_result3", 32'(q3.size()), 1);
        else begin
          e = q3.pop_front();
          chk("sum3", 32'(s3), 32'(e.s));
          chk("cout3", 32'(co3), 32'(e.c));
`ifdef DIGIT_SERIAL_OVF_EN
          chk("ovf3", 32'(ovf3), 32'(e.o));
`endif
        end
      end
    end
    prev_ov3 = ov3;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("timeout_in_ready", 32'(in_ready), 1);
  endtask

  task automatic send(input logic [11:0] va, input logic [11:0] vb, input logic vc,
                      input logic push, input logic [11:0] es, input logic ec, input logic eo);
    exp_t e;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b1; a = va; b = vb; cin = vc;
    if (push) begin
      e.s = es; e.c = ec; e.o = eo;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 12'($urandom); b = 12'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain12", 32'(q.size()), 0);
  endtask

  task automatic send3(input logic [2:0] va, input logic [2:0] vb, input logic vc,
                       input logic [2:0] es, input logic ec, input logic eo);
    exp_t e;
    int n = 0;
    while (!rdy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    v3 = 1'b1; a3 = va; b3 = vb; c3 = vc;
    e.s = {9'd0, es}; e.c = ec; e.o = eo;
    q3.push_back(e);
    @(posedge clk); #1;
    v3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom);
    n = 0;
    while (q3.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain3", 32'(q3.size()), 0);
  endtask

  initial begin
    logic [11:0] s0;
    logic        c0;
    int          n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);

    send(12'hFFF, 12'h001, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0);
    drain();
    send(12'h000, 12'h000, 1'b1, 1'b1, 12'h001, 1'b0, 1'b0);
    drain();
    send(12'hABC, 12'h123, 1'b0, 1'b1, 12'hBDF, 1'b0, 1'b0);
    drain();
    send(12'h7FF, 12'h001, 1'b0, 1'b1, 12'h800, 1'b0, 1'b1);
    drain();
    send(12'h800, 12'h800, 1'b1, 1'b1, 12'h001, 1'b1, 1'b1);
    drain();
    send(12'hFFF, 12'hFFF, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0);
    drain();

    // Stall in DONE; a new request must be ignored.
    out_ready = 1'b0;
    send(12'h700, 12'h100, 1'b0, 1'b1, 12'h800, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 32'(out_valid), 1);
    s0 = sum; c0 = cout;
    #1 in_valid = 1'b1; a = 12'h111; b = 12'h222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sum", 32'(sum), 32'(s0));
      chk("stall_cout", 32'(cout), 32'(c0));
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_hs_in_ready", 32'(in_ready), 1);
    chk("after_hs_busy", 32'(busy), 0);
    chk("stall_queue_empty", 32'(q.size()), 0);

    // Reset during the second RUN cycle aborts the operation.
    send(12'h123, 12'h456, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    repeat (8) @(negedge clk);
    send(12'h005, 12'h003, 1'b0, 1'b1, 12'h008, 1'b0, 1'b0);
    drain();

    send3(3'h5, 3'h3, 1'b0, 3'h0, 1'b1, 1'b0);
    send3(3'h7, 3'h7, 1'b1, 3'h7, 1'b1, 1'b0);
    send3(3'h3, 3'h1, 1'b0, 3'h4, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
- REQ-001: Parameter WIDTH, default 12; operand/result width in bits; SHALL be a multiple of 3 and >= 3. Processing uses 3-bit digits, so N = WIDTH/3 digits.
- REQ-002: clk, input, 1, single clock; all state updates on its rising edge.
- REQ-003: rst, input, 1, reset; synchronous and active-high.
- REQ-004: in_valid, input, 1, operand request.
- REQ-005: in_ready, output, 1, block can accept operands.
- REQ-006: a, input, WIDTH, operand A, unsigned.
- REQ-007: b, input, WIDTH, operand B, unsigned.
- REQ-008: cin, input, 1, carry-in to digit 0.
- REQ-009: out_valid, output, 1, result available.
- REQ-010: out_ready, input, 1, consumer accepts the result.
- REQ-011: sum, output, WIDTH, result bits.
- REQ-012: cout, output, 1, carry out of the most significant digit.
- REQ-013: busy, output, 1, high in RUN and DONE.

Function
- REQ-014: FSM states are IDLE, RUN and DONE.
  - in_ready SHALL be 1 only in IDLE.
  - out_valid SHALL be 1 only in DONE.
- REQ-015: Accept occurs when state is IDLE and in_valid is 1.
  - On accept, the block SHALL register a, b and cin.
  - The carry register SHALL be loaded with cin.
  - The digit counter and the sum register SHALL be cleared.
  - Next state SHALL be RUN.
- REQ-016: In RUN, each cycle SHALL process digit k = counter as {c,s} = a[3k+2:3k] + b[3k+2:3k] + carry.
  - s SHALL be written to sum[3k+2:3k].
  - carry SHALL be updated to c.
  - counter SHALL increment by 1.
- REQ-017: When counter == N-1 in RUN, the digit SHALL be processed, cout SHALL be set to the final carry, and next state SHALL be DONE.
- REQ-018: Latency: out_valid SHALL rise exactly N clock edges after the accept edge. For WIDTH=12 this is 4 edges.
- REQ-019: In DONE, sum, cout and out_valid SHALL hold stable until out_ready is 1. The next state after that SHALL be IDLE.
- REQ-020: There is no back-to-back overlap. Minimum initiation interval is N+2 cycles. in_valid SHALL be ignored outside IDLE.
- REQ-021: Arithmetic is modulo 2^WIDTH on sum, with the carry reported in cout. The result SHALL equal a + b + cin exactly, with cout as bit WIDTH.
- REQ-022: sum is undefined for the consumer outside DONE. Partial digits are visible during RUN and SHALL NOT be relied upon.
- REQ-023: Operand changes on a/b after accept SHALL NOT affect the result.

Reset
- REQ-024: When rst=1 at a clock edge, the block SHALL set:
  - state to IDLE;
  - counter, carry, sum, cout and the operand registers to 0;
  - out_valid and busy to 0, and in_ready to 1 on the following cycle.
- REQ-025: rst SHALL take priority over an accept, an in-flight RUN and a pending DONE. An aborted operation SHALL produce no out_valid.

Configuration
- REQ-026: Macro DIGIT_SERIAL_OVF_EN.
  - When defined, the block SHALL add an output port ovf (1 bit), reset value 0.
  - ovf SHALL be set in DONE as the two's-complement overflow of the final digit: the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
  - ovf SHALL be held with sum until the handshake completes.
  - When not defined, the port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification (WIDTH=12 unless stated)
- REQ-027: Accept a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1, out_valid rises 4 edges after accept.
- REQ-028: Accept a=0x000, b=0x000, cin=1 -> sum=0x001, cout=0; accept a=0xABC, b=0x123 -> sum=0xBDF, cout=0.
- REQ-029: Result in DONE with out_ready held 0 for 3 cycles -> sum, cout and out_valid are stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
- REQ-030: rst=1 during the second RUN cycle -> next cycle state is IDLE, out_valid=0, sum=0, no result is ever emitted. A subsequent accept of 0x005+0x003 yields 0x008.
- REQ-031: With DIGIT_SERIAL_OVF_EN defined:
  - 0x7FF+0x001 -> ovf=1, sum=0x800;
  - 0xFFF+0x001 -> ovf=0, cout=1.
- REQ-032: WIDTH=3: 0x5+0x3, cin=0 -> sum=0x0, cout=1, out_valid 1 edge after accept.
